// File: rtl/pu_output_packer.sv
// Serializes PU write beats into 64-bit words, queues them in a small FIFO and
// tracks per-layer word counts. Define PACKER_RELU_EN to zero negative lanes on load.
//
// state   | meaning
// IDLE    | waiting for layer_start
// RUN     | accepting beats and pushing 64-bit slices into the FIFO
// DRAIN   | all layer words pushed, waiting for the FIFO to empty
// DONE    | one-cycle layer_done pulse
module pu_output_packer #(
  parameter int OP_WIDTH   = 16,
  parameter int NUM_PE     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 20
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         layer_start,
  input  logic [CNT_WIDTH-1:0]         cfg_num_words,
  input  logic                         pu_wr_req,
  input  logic [NUM_PE*OP_WIDTH-1:0]   pu_wr_data,
  output logic                         pu_wr_ready,
  output logic                         wr_valid,
  output logic [63:0]                  wr_data,
  input  logic                         wr_ready,
  output logic                         layer_done,
  output logic                         busy
);

  localparam int BW  = NUM_PE * OP_WIDTH;
  localparam int WPB = BW / 64;
  localparam int SW  = $clog2(WPB + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               state;
  logic [SW-1:0]        slice_cnt;
  logic [BW-1:0]        shreg;
  logic [CNT_WIDTH-1:0] target;
  logic [CNT_WIDTH-1:0] in_cnt;
  logic [CNT_WIDTH-1:0] out_cnt;
  logic [CNT_WIDTH-1:0] in_cnt_nxt;
  logic [CNT_WIDTH-1:0] out_cnt_nxt;

  logic [63:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          fifo_cnt;

  logic                 empty;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 accept;
  logic [BW-1:0]        beat_in;

  assign empty       = (fifo_cnt == '0);
  assign full        = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign wr_valid    = !empty;
  assign wr_data     = empty ? '0 : mem[rd_ptr];
  assign pop         = wr_valid && wr_ready;
  assign pu_wr_ready = (state == S_RUN) && (slice_cnt == '0);
  assign accept      = pu_wr_req && pu_wr_ready;
  // a same-cycle pop frees the slot, so a full FIFO can still take a push
  assign push        = (state == S_RUN) && (slice_cnt != '0) && (!full || pop);
  assign in_cnt_nxt  = in_cnt + 1'b1;
  assign out_cnt_nxt = out_cnt + 1'b1;
  assign layer_done  = (state == S_DONE);
  assign busy        = (state != S_IDLE);

  always_comb begin
    beat_in = pu_wr_data;
`ifdef PACKER_RELU_EN
    for (int k = 0; k < NUM_PE; k++) begin
      if (pu_wr_data[k*OP_WIDTH + OP_WIDTH - 1]) beat_in[k*OP_WIDTH +: OP_WIDTH] = '0;
    end
`else
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      slice_cnt <= '0;
      shreg     <= '0;
      target    <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
    end else begin
      if (pop) out_cnt <= out_cnt_nxt;
      case (state)
        S_IDLE: begin
          if (layer_start) begin
            target  <= cfg_num_words;
            in_cnt  <= '0;
            out_cnt <= '0;
            state   <= (cfg_num_words == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            shreg     <= beat_in;
            slice_cnt <= SW'(WPB);
          end else if (push) begin
            shreg  <= shreg >> 64;
            in_cnt <= in_cnt_nxt;
            if (in_cnt_nxt == target) begin
              slice_cnt <= '0;
              state     <= S_DRAIN;
            end else begin
              slice_cnt <= slice_cnt - 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // look at the post-handshake count so DONE lands the cycle after the last pop
          if (pop && (out_cnt_nxt == target)) state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shreg[63:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_pu_output_packer.sv
// Directed bench for pu_output_packer: a 4-lane and an 8-lane instance share clock and reset.
module tb_pu_output_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic         ls4, req4, rdy4, wv4, wrr4, ld4, busy4;
  logic [19:0]  cfg4;
  logic [63:0]  data4, wd4;
  logic         ls8, req8, rdy8, wv8, wrr8, ld8, busy8;
  logic [19:0]  cfg8;
  logic [127:0] data8;
  logic [63:0]  wd8;

  pu_output_packer #(.OP_WIDTH(16), .NUM_PE(4), .FIFO_DEPTH(8), .CNT_WIDTH(20)) dut4 (
    .clk(clk), .reset(reset), .layer_start(ls4), .cfg_num_words(cfg4),
    .pu_wr_req(req4), .pu_wr_data(data4), .pu_wr_ready(rdy4),
    .wr_valid(wv4), .wr_data(wd4), .wr_ready(wrr4),
    .layer_done(ld4), .busy(busy4)
  );

  pu_output_packer #(.OP_WIDTH(16), .NUM_PE(8), .FIFO_DEPTH(8), .CNT_WIDTH(20)) dut8 (
    .clk(clk), .reset(reset), .layer_start(ls8), .cfg_num_words(cfg8),
    .pu_wr_req(req8), .pu_wr_data(data8), .pu_wr_ready(rdy8),
    .wr_valid(wv8), .wr_data(wd8), .wr_ready(wrr8),
    .layer_done(ld8), .busy(busy8)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] w4_q[$];
  logic [63:0] w8_q[$];
  int h4_q[$], h8_q[$], l4_q[$], l8_q[$];

  always @(negedge clk) begin
    if (wv4 && wrr4) begin w4_q.push_back(wd4); h4_q.push_back(cyc); end
    if (wv8 && wrr8) begin w8_q.push_back(wd8); h8_q.push_back(cyc); end
    if (ld4) l4_q.push_back(cyc);
    if (ld8) l8_q.push_back(cyc);
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start4(input logic [19:0] cfg);
    ls4 = 1'b1; cfg4 = cfg; tick(); ls4 = 1'b0;
  endtask

  task automatic start8(input logic [19:0] cfg);
    ls8 = 1'b1; cfg8 = cfg; tick(); ls8 = 1'b0;
  endtask

  task automatic send4(input logic [63:0] d);
    int t;
    req4 = 1'b1; data4 = d; t = 0;
    while (!rdy4 && t < 100) begin tick(); t++; end
    chk("send4_ready", rdy4, 1);
    tick();
    req4 = 1'b0;
  endtask

  task automatic send8(input logic [127:0] d);
    int t;
    req8 = 1'b1; data8 = d; t = 0;
    while (!rdy8 && t < 100) begin tick(); t++; end
    chk("send8_ready", rdy8, 1);
    tick();
    req8 = 1'b0;
  endtask

  task automatic wait_ld4(input int base);
    int t;
    t = 0;
    while (l4_q.size() <= base && t < 300) begin tick(); t++; end
    chk("ld4_seen", l4_q.size() > base, 1);
  endtask

  task automatic wait_ld8(input int base);
    int t;
    t = 0;
    while (l8_q.size() <= base && t < 300) begin tick(); t++; end
    chk("ld8_seen", l8_q.size() > base, 1);
  endtask

  function automatic logic [63:0] bp_word(input int i);
    return {16'(4*i+4), 16'(4*i+3), 16'(4*i+2), 16'(4*i+1)};
  endfunction

  int hb, lb, t;
  logic ready_low_ok;
  logic [63:0] relu_exp;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    ls4 = 0; cfg4 = '0; req4 = 0; data4 = '0; wrr4 = 1'b1;
    ls8 = 0; cfg8 = '0; req8 = 0; data8 = '0; wrr8 = 1'b1;
    tick(3);
    chk("rst_ready4", rdy4, 0);
    chk("rst_valid4", wv4, 0);
    chk("rst_data4", wd4, 64'h0);
    chk("rst_done4", ld4, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_ready8", rdy8, 0);
    chk("rst_valid8", wv8, 0);
    reset = 1'b1;
    tick(2);

    // basic 4-lane packing
    hb = w4_q.size(); lb = l4_q.size();
    start4(20'd3);
    chk("basic_busy", busy4, 1);
    chk("basic_ready", rdy4, 1);
    send4(64'h0004_0003_0002_0001);
    send4(64'h0008_0007_0006_0005);
    send4(64'h000C_000B_000A_0009);
    wait_ld4(lb);
    tick(3);
    chk("basic_count", w4_q.size() - hb, 3);
    if (w4_q.size() - hb >= 3) begin
      chk("basic_w0", w4_q[hb],   64'h0004_0003_0002_0001);
      chk("basic_w1", w4_q[hb+1], 64'h0008_0007_0006_0005);
      chk("basic_w2", w4_q[hb+2], 64'h000C_000B_000A_0009);
      chk("basic_ld_timing", l4_q[lb], h4_q[h4_q.size()-1] + 1);
    end
    chk("basic_ld_once", l4_q.size() - lb, 1);
    chk("basic_idle", busy4, 0);

    // two words per beat
    hb = w8_q.size(); lb = l8_q.size();
    start8(20'd4);
    send8(128'h0008_0007_0006_0005_0004_0003_0002_0001);
    chk("wpb2_ready_c1", rdy8, 0);
    tick();
    chk("wpb2_ready_c2", rdy8, 0);
    tick();
    chk("wpb2_ready_c3", rdy8, 1);
    send8(128'h0010_000F_000E_000D_000C_000B_000A_0009);
    wait_ld8(lb);
    tick(2);
    chk("wpb2_count", w8_q.size() - hb, 4);
    if (w8_q.size() - hb >= 4) begin
      chk("wpb2_w0", w8_q[hb],   64'h0004_0003_0002_0001);
      chk("wpb2_w1", w8_q[hb+1], 64'h0008_0007_0006_0005);
      chk("wpb2_w2", w8_q[hb+2], 64'h000C_000B_000A_0009);
      chk("wpb2_w3", w8_q[hb+3], 64'h0010_000F_000E_000D);
      chk("wpb2_ld_timing", l8_q[lb], h8_q[h8_q.size()-1] + 1);
    end

    // backpressure: 8 words fill the FIFO, the 9th beat sits in the shift register
    wrr4 = 1'b0;
    hb = w4_q.size(); lb = l4_q.size();
    start4(20'd12);
    for (int i = 0; i < 9; i++) send4(bp_word(i));
    ready_low_ok = 1'b1;
    repeat (20) begin
      tick();
      if (rdy4) ready_low_ok = 1'b0;
    end
    chk("bp_ready_low", ready_low_ok, 1);
    chk("bp_no_handshake", w4_q.size() - hb, 0);
    chk("bp_valid", wv4, 1);
    chk("bp_head", wd4, bp_word(0));
    wrr4 = 1'b1;
    for (int i = 9; i < 12; i++) send4(bp_word(i));
    wait_ld4(lb);
    tick(2);
    chk("bp_count", w4_q.size() - hb, 12);
    if (w4_q.size() - hb >= 12) begin
      for (int i = 0; i < 12; i++) chk("bp_word", w4_q[hb+i], bp_word(i));
    end
    chk("bp_ld_once", l4_q.size() - lb, 1);

    // truncation: only the low slice of the second beat is emitted
    hb = w8_q.size(); lb = l8_q.size();
    start8(20'd3);
    send8(128'h0018_0017_0016_0015_0014_0013_0012_0011);
    send8(128'h0028_0027_0026_0025_0024_0023_0022_0021);
    wait_ld8(lb);
    tick(2);
    chk("trunc_count", w8_q.size() - hb, 3);
    if (w8_q.size() - hb >= 3) begin
      chk("trunc_w0", w8_q[hb],   64'h0014_0013_0012_0011);
      chk("trunc_w1", w8_q[hb+1], 64'h0018_0017_0016_0015);
      chk("trunc_w2", w8_q[hb+2], 64'h0024_0023_0022_0021);
      chk("trunc_ld_timing", l8_q[lb], h8_q[h8_q.size()-1] + 1);
    end
    chk("trunc_ld_once", l8_q.size() - lb, 1);

    // zero-length layer
    hb = w8_q.size();
    start8(20'd0);
    chk("zero_ld", ld8, 1);
    chk("zero_valid", wv8, 0);
    tick();
    chk("zero_ld_fall", ld8, 0);
    chk("zero_idle", busy8, 0);
    chk("zero_no_words", w8_q.size() - hb, 0);

    // lane clamping on load
`ifdef PACKER_RELU_EN
    relu_exp = 64'h7FFF_0000_0000_0005;
`else
    relu_exp = 64'h7FFF_8000_FFFF_0005;
`endif
    hb = w4_q.size(); lb = l4_q.size();
    start4(20'd1);
    send4(64'h7FFF_8000_FFFF_0005);
    wait_ld4(lb);
    tick();
    chk("relu_count", w4_q.size() - hb, 1);
    if (w4_q.size() - hb >= 1) chk("relu_word", w4_q[hb], relu_exp);

    // reset mid-layer with two words queued
    wrr4 = 1'b0;
    hb = w4_q.size(); lb = l4_q.size();
    start4(20'd5);
    send4(bp_word(20));
    send4(bp_word(21));
    tick();
    chk("mid_pre_ready", rdy4, 1);
    chk("mid_pre_valid", wv4, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_valid", wv4, 0);
    chk("mid_busy", busy4, 0);
    chk("mid_ready", rdy4, 0);
    tick(2);
    reset = 1'b1;
    wrr4 = 1'b1;
    tick(3);
    chk("mid_no_ld", l4_q.size() - lb, 0);
    chk("mid_no_words", w4_q.size() - hb, 0);
    start4(20'd1);
    send4(64'h0123_0456_0789_0ABC);
    wait_ld4(lb);
    tick();
    chk("post_count", w4_q.size() - hb, 1);
    if (w4_q.size() - hb >= 1) chk("post_word", w4_q[hb], 64'h0123_0456_0789_0ABC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
